// File: rtl/i2s_pkg.sv
// Shared constants, the stereo sample payload and the I2S frame layout for i2s_audio_tx.
package i2s_pkg;

  localparam int unsigned SAMPLE_W       = 16;
  localparam int unsigned SLOT_W         = 32;
  localparam int unsigned FRAME_BITS     = 64;
  localparam int unsigned SCLK_HALF_DEF  = 8;
  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned PAD_W          = SLOT_W - SAMPLE_W - 1;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;

  // One-bit delay after each slot boundary, sample MSB first, zero fill to the slot end.
  function automatic logic [FRAME_BITS-1:0] pack_frame(input stereo_sample_t s);
    return {1'b0, s.left, {PAD_W{1'b0}}, 1'b0, s.right, {PAD_W{1'b0}}};
  endfunction

endpackage

// File: rtl/i2s_audio_tx_sample_fifo.sv
// Synchronous FIFO of stereo sample pairs with registered level, full and empty flags.
module sample_fifo
  import i2s_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_push,
  input  stereo_sample_t i_push_data,
  input  logic           i_pop,
  output stereo_sample_t o_head,
  output logic [LVL_W-1:0] o_level,
  output logic           o_full,
  output logic           o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  stereo_sample_t   r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [LVL_W-1:0] w_level_next;

  assign w_push       = i_push && !r_full;
  assign w_pop        = i_pop && !r_empty;
  assign w_level_next = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

  // Storage carries no reset; validity is tracked entirely by the pointers and level.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_next;
      r_full  <= (w_level_next == LVL_W'(DEPTH));
      r_empty <= (w_level_next == '0);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips-I2S transmitter: buffers stereo pairs, generates SCLK/LRCLK and shifts 64-bit frames.
module i2s_audio_tx
  import i2s_pkg::*;
#(
  parameter int unsigned SCLK_HALF  = SCLK_HALF_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        sample_valid,
  input  logic [SAMPLE_W-1:0]         sample_left,
  input  logic [SAMPLE_W-1:0]         sample_right,
  output logic                        sample_ready,
  output logic                        i2s_sclk,
  output logic                        i2s_lrclk,
  output logic                        i2s_sd,
  output logic                        frame_tick,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  underrun_cnt
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int unsigned BIT_W = $clog2(FRAME_BITS);

  logic [DIV_W-1:0]      r_div_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_sclk;
  logic                  r_lrclk;
  logic                  r_sd;
  logic                  r_frame_tick;
  logic [7:0]            r_underrun_cnt;

  logic                  w_div_wrap;
  logic                  w_fall;
  logic                  w_load;
  logic [BIT_W-1:0]      w_bit_next;
  logic [FRAME_BITS-1:0] w_frame;
  logic                  w_push;
  logic                  w_pop;
  stereo_sample_t        w_push_data;
  stereo_sample_t        w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [LVL_W-1:0]      w_level;

  assign w_div_wrap  = (r_div_cnt == DIV_W'(SCLK_HALF - 1));
  assign w_fall      = w_div_wrap && r_sclk;
  assign w_bit_next  = r_bit_cnt + BIT_W'(1);
  assign w_load      = w_fall && (r_bit_cnt == BIT_W'(FRAME_BITS - 1));
  assign w_frame     = w_empty ? '0 : pack_frame(w_head);

  assign w_push      = sample_valid && !w_full;
  assign w_pop       = w_load && !w_empty;
  assign w_push_data = '{left: sample_left, right: sample_right};

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .i_clk       (Clk),
    .i_rst       (Reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_level     (w_level),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // SD and LRCLK only move on SCLK fall events so the codec samples stable data on rises.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_div_cnt      <= '0;
      r_bit_cnt      <= BIT_W'(FRAME_BITS - 1);
      r_shift        <= '0;
      r_sclk         <= 1'b0;
      r_lrclk        <= 1'b1;
      r_sd           <= 1'b0;
      r_frame_tick   <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_div_cnt    <= w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
      r_frame_tick <= w_load;
      if (w_div_wrap) r_sclk <= ~r_sclk;
      if (w_fall) begin
        r_bit_cnt <= w_bit_next;
        r_lrclk   <= (w_bit_next >= BIT_W'(SLOT_W));
        if (w_load) begin
          r_sd    <= w_frame[FRAME_BITS-1];
          r_shift <= {w_frame[FRAME_BITS-2:0], 1'b0};
          if (w_empty && (r_underrun_cnt != 8'hFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 8'd1;
          end
        end else begin
          r_sd    <= r_shift[FRAME_BITS-1];
          r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

  assign sample_ready = ~w_full;
  assign fifo_level   = w_level;
  assign i2s_sclk     = r_sclk;
  assign i2s_lrclk    = r_lrclk;
  assign i2s_sd       = r_sd;
  assign frame_tick   = r_frame_tick;
  assign underrun_cnt = r_underrun_cnt;

endmodule
